// File: rtl/fir_mac_sched.sv
// Time-multiplexed polyphase FIR scheduler: one shared MAC sequences the K taps of
// each of the UP output phases for every accepted symbol.
module fir_mac_sched #(
  parameter int NTAPS = 16,
  parameter int UP    = 4,
  parameter int DW    = 4,
  parameter int CW    = 8,
  parameter int OW    = 16
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      i_cfg_we,
  input  logic [$clog2(NTAPS)-1:0]  i_cfg_addr,
  input  logic signed [CW-1:0]      i_cfg_data,
  output logic                      o_cfg_busy,
  input  logic                      i_sym_valid,
  input  logic signed [DW-1:0]      i_sym_data,
  output logic                      o_sym_ready,
  output logic                      o_out_valid,
  output logic signed [OW-1:0]      o_out_data,
  input  logic                      i_out_ready
);

  localparam int K   = NTAPS / UP;
  localparam int AW  = $clog2(NTAPS);
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int PW  = (UP > 1) ? $clog2(UP) : 1;
  localparam int PRW = DW + CW;
  localparam int ACW = DW + CW + $clog2(K);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [CW-1:0]    r_h    [NTAPS];
  logic signed [DW-1:0]    r_hist [K];
  logic [PW-1:0]           r_p;
  logic [KW-1:0]           r_k;
  logic signed [ACW-1:0]   r_acc;

  logic [AW-1:0]           w_idx;
  logic signed [PRW-1:0]   w_prod;
  logic signed [ACW-1:0]   w_term;
  logic                    w_last_k;
  logic                    w_last_p;
  logic                    w_sym_fire;
  logic                    w_out_fire;

  // Width constraint on OW/ACW guarantees these never lose information.
  function automatic logic signed [ACW-1:0] ext_prod(input logic signed [PRW-1:0] v);
    return ACW'(v);
  endfunction

  function automatic logic signed [OW-1:0] ext_out(input logic signed [ACW-1:0] v);
    return OW'(v);
  endfunction

  assign w_idx      = AW'(r_k) * AW'(UP) + AW'(r_p);
  assign w_prod     = r_h[w_idx] * r_hist[r_k];
  assign w_term     = ext_prod(w_prod);
  assign w_last_k   = (r_k == KW'(K - 1));
  assign w_last_p   = (r_p == PW'(UP - 1));
  assign w_sym_fire = (r_state == S_IDLE) && i_sym_valid;
  assign w_out_fire = (r_state == S_OUT) && i_out_ready;
  assign o_out_data = ext_out(r_acc);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_sym_valid) w_state_nxt = S_MAC;
      S_MAC:   if (w_last_k)    w_state_nxt = S_OUT;
      S_OUT:   if (i_out_ready) w_state_nxt = w_last_p ? S_IDLE : S_MAC;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs depend on registered state only.
  always_comb begin
    o_sym_ready = 1'b0;
    o_cfg_busy  = 1'b1;
    o_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_sym_ready = 1'b1;
        o_cfg_busy  = 1'b0;
      end
      S_OUT:   o_out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NTAPS; i++) r_h[i] <= '0;
      for (int i = 0; i < K; i++)     r_hist[i] <= '0;
      r_p   <= '0;
      r_k   <= '0;
      r_acc <= '0;
    end else begin
      if ((r_state == S_IDLE) && i_cfg_we) r_h[i_cfg_addr] <= i_cfg_data;
      if (w_sym_fire) begin
        r_hist[0] <= i_sym_data;
        for (int i = 1; i < K; i++) r_hist[i] <= r_hist[i-1];
        r_p <= '0;
        r_k <= '0;
      end
      if (r_state == S_MAC) begin
        r_acc <= (r_k == '0) ? w_term : r_acc + w_term;
        r_k   <= w_last_k ? '0 : r_k + KW'(1);
      end
      if (w_out_fire && !w_last_p) begin
        r_p <= r_p + PW'(1);
        r_k <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed and random scoreboard bench for fir_mac_sched with an independent
// polyphase reference model.
module tb_fir_mac_sched;
  localparam int NTAPS = 16;
  localparam int UP    = 4;
  localparam int K     = 4;

  logic              clk = 1'b0;
  logic              nrst;
  logic              i_cfg_we;
  logic [3:0]        i_cfg_addr;
  logic signed [7:0] i_cfg_data;
  logic              o_cfg_busy;
  logic              i_sym_valid;
  logic signed [3:0] i_sym_data;
  logic              o_sym_ready;
  logic              o_out_valid;
  logic signed [15:0] o_out_data;
  logic              i_out_ready;

  int checks = 0;
  int errors = 0;
  int mh[NTAPS];
  int mhist[K];
  int q[$];
  int obs[UP];
  int n_out = 0;

  fir_mac_sched #(.NTAPS(NTAPS), .UP(UP), .DW(4), .CW(8), .OW(16)) dut (
    .clk(clk), .nrst(nrst),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
    .o_cfg_busy(o_cfg_busy),
    .i_sym_valid(i_sym_valid), .i_sym_data(i_sym_data), .o_sym_ready(o_sym_ready),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int d);
    i_cfg_we   = 1'b1;
    i_cfg_addr = a[3:0];
    i_cfg_data = d[7:0];
    mh[a]      = d;
    step();
    i_cfg_we   = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NTAPS; i++) mh[i] = 0;
    for (int i = 0; i < K; i++) mhist[i] = 0;
    q.delete();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!o_sym_ready) begin
      step();
      n++;
      if (n > 100) begin
        $display("FAIL sym_ready_timeout got 0 want 1");
        $fatal(1, "sym_ready never rose");
      end
    end
  endtask

  task automatic accept(input int s);
    int y;
    i_sym_valid = 1'b1;
    i_sym_data  = s[3:0];
    for (int k = K - 1; k > 0; k--) mhist[k] = mhist[k-1];
    mhist[0] = s;
    for (int p = 0; p < UP; p++) begin
      y = 0;
      for (int k = 0; k < K; k++) y += mh[k*UP + p] * mhist[k];
      q.push_back(y);
    end
    step();
    i_sym_valid = 1'b0;
    i_sym_data  = '0;
  endtask

  // stall < 0: random per-phase stalls; otherwise stall cycles at phase 0 only.
  task automatic send_sym(input int s, input int stall, input bit lock);
    int n, y, st;
    wait_ready();
    accept(s);
    if (lock) begin
      i_cfg_we   = 1'b1;
      i_cfg_addr = 4'd0;
      i_cfg_data = 8'sd99;
      chk("busy_in_mac", o_cfg_busy, 1);
      step();
      i_cfg_we   = 1'b0;
    end
    for (int p = 0; p < UP; p++) begin
      n = (lock && p == 0) ? 1 : 0;
      while (!o_out_valid && n <= K + 2) begin
        step();
        n++;
      end
      chk("latency", n, K);
      chk("ready_low_out", o_sym_ready, 0);
      y = (q.size() > 0) ? q.pop_front() : 32'h7fff_ffff;
      if (stall < 0) st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      else           st = (p == 0) ? stall : 0;
      if (st > 0) begin
        i_out_ready = 1'b0;
        repeat (st) begin
          step();
          chk("stall_valid", o_out_valid, 1);
          chk("stall_data", $signed(o_out_data), y);
          chk("stall_ready", o_sym_ready, 0);
        end
        i_out_ready = 1'b1;
      end
      chk("data", $signed(o_out_data), y);
      obs[p] = $signed(o_out_data);
      if (o_out_valid) n_out++;
      step();
    end
    chk("idle_after", o_sym_ready, 1);
  endtask

  initial begin
    int n0, s;
    nrst = 1'b0;
    i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
    i_sym_valid = 1'b0; i_sym_data = '0; i_out_ready = 1'b1;
    model_reset();
    step(); step();
    chk("rst_sym_ready", o_sym_ready, 1);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_data", $signed(o_out_data), 0);
    chk("rst_cfg_busy", o_cfg_busy, 0);
    nrst = 1'b1;
    step();

    // Impulse response through the polyphase taps
    for (int i = 0; i < NTAPS; i++) cfg_write(i, i + 1);
    for (int j = 0; j < 4; j++) begin
      send_sym((j == 0) ? 1 : 0, 0, 1'b0);
      for (int p = 0; p < UP; p++) chk("impulse", obs[p], 4*j + p + 1);
    end
    send_sym(0, 0, 1'b0);
    for (int p = 0; p < UP; p++) chk("impulse_tail", obs[p], 0);

    // Backpressure on the first OUT
    send_sym(2, 10, 1'b0);
    for (int p = 0; p < UP; p++) chk("bp_data", obs[p], 2 * (p + 1));

    // Coefficient write ignored while busy, honoured in IDLE
    for (int j = 0; j < 3; j++) send_sym(0, 0, 1'b0);
    send_sym(1, 0, 1'b1);
    chk("lock_ignored", obs[0], 1);
    cfg_write(0, 99);
    for (int j = 0; j < 3; j++) send_sym(0, 0, 1'b0);
    send_sym(1, 0, 1'b0);
    chk("lock_idle_write", obs[0], 99);

    // Full-scale products
    for (int i = 0; i < NTAPS; i++) cfg_write(i, -128);
    for (int j = 0; j < 4; j++) send_sym(-7, 0, 1'b0);
    for (int p = 0; p < UP; p++) chk("fs_neg128", obs[p], 3584);
    for (int i = 0; i < NTAPS; i++) cfg_write(i, 127);
    for (int j = 0; j < 4; j++) send_sym(-7, 0, 1'b0);
    for (int p = 0; p < UP; p++) chk("fs_pos127", obs[p], -3556);

    // Asynchronous reset two cycles into MAC
    wait_ready();
    accept(5);
    step(); step();
    nrst = 1'b0;
    #1;
    chk("amid_out_valid", o_out_valid, 0);
    chk("amid_sym_ready", o_sym_ready, 1);
    chk("amid_cfg_busy", o_cfg_busy, 0);
    model_reset();
    step();
    nrst = 1'b1;
    step();
    send_sym(3, 0, 1'b0);
    for (int p = 0; p < UP; p++) chk("post_rst_zero", obs[p], 0);

    // Random 8-PAM with random stalls and occasional coefficient updates
    for (int i = 0; i < NTAPS; i++) cfg_write(i, $urandom_range(0, 255) - 128);
    n0 = n_out;
    for (int j = 0; j < 1000; j++) begin
      if (j % 97 == 0) cfg_write($urandom_range(0, NTAPS - 1), $urandom_range(0, 255) - 128);
      s = 2 * $urandom_range(0, 7) - 7;
      send_sym(s, -1, 1'b0);
    end
    chk("rand_count", n_out - n0, 1000 * UP);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
